// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle instruction sequencer for the 9-bit-ISA core.
// Owns the PC, retires one instruction per cycle, stalls on data-memory
// ops until acknowledged (with a timeout), resolves jumps through an
// external LUT and stops on halt while reporting the running cycle count.
module seq_ctrl #(
  parameter int PC_W     = 8,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [8:0]       instr,
  input  logic             gt_flag,
  input  logic             eq_flag,
  input  logic [PC_W-1:0]  lut_target,
  input  logic             mem_ack,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       lut_idx,
  output logic             exec_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             running,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt
);

  // Wait counter is 8 bits wide, enough for MAX_WAIT up to 255.
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;

  // Opcode decode of the instruction currently addressed by pc.
  logic is_jg, is_jge, is_jmp, is_ldr, is_str, is_ldi, is_sti, is_halt;
  logic is_mem, is_store, br_taken;

  assign is_jg    = (instr[8:4] == 5'b10000);
  assign is_jge   = (instr[8:4] == 5'b10001);
  assign is_jmp   = (instr[8:5] == 4'b1001);
  assign is_ldr   = (instr[8:3] == 6'b101110);
  assign is_str   = (instr[8:3] == 6'b101111);
  assign is_ldi   = (instr[8:3] == 6'b110000);
  assign is_sti   = (instr[8:3] == 6'b110001);
  assign is_halt  = (instr == 9'h1FF);
  assign is_mem   = is_ldr | is_str | is_ldi | is_sti;
  assign is_store = is_str | is_sti;
  assign br_taken = is_jmp | (is_jg & gt_flag) | (is_jge & (gt_flag | eq_flag));

  assign lut_idx   = instr[3:0];
  assign pc        = pc_q;
  assign cycle_cnt = cnt_q;
  assign running   = (state_q == S_EXEC) || (state_q == S_MEM_WAIT);
  assign done      = (state_q == S_HALT);
  // err_q is only ever set on the transition into HALT and cleared on leaving it.
  assign err       = err_q;

  // Next-state, PC/counter update and per-cycle strobes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    err_d   = err_q;
    exec_en = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;

    // Saturating run-time counter, advanced in every running cycle.
    if (running && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_mem) begin
          // Request goes out in the decode cycle; pc freezes so instr stays put.
          mem_req = 1'b1;
          mem_we  = is_store;
          wait_d  = 8'd1;
          state_d = S_MEM_WAIT;
        end else begin
          exec_en = 1'b1;
          pc_d    = br_taken ? lut_target : pc_q + 1'b1;
        end
      end

      S_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        // An ack on the final allowed cycle still retires normally.
        if (mem_ack) begin
          exec_en = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = S_EXEC;
        end else if (wait_q == MAX_WAIT_C) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
Multi-cycle instruction sequencer for the 9-bit-ISA core.
- Owns the program counter and drives the instruction ROM address.
- Retires one instruction per cycle, or stalls on data-memory ops until acknowledged.
- Resolves jg/jge/jmp through the external jump LUT.
- Stops on halt and reports the total cycle count.

Parameters:
PC_W, 8, program counter / ROM address width
CNT_W, 16, cycle counter width
MAX_WAIT, 15, maximum MEM_WAIT cycles before the error halt (1..255)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset; synchronous, active-low
start  in  1  run request; sampled in IDLE and HALT only
instr  in  9  instruction at pc (combinational ROM read)
gt_flag  in  1  datapath "greater" flag from last cmp
eq_flag  in  1  datapath "equal" flag from last cmp
lut_target  in  PC_W  jump LUT output for lut_idx
mem_ack  in  1  data memory completion
pc  out  PC_W  current program counter
lut_idx  out  4  equals instr[3:0] (combinational)
exec_en  out  1  retire strobe; register/flag write enable for the current instr
mem_req  out  1  memory request, level, held until ack
mem_we  out  1  1 = store (str/sti), valid while mem_req
running  out  1  high in EXEC or MEM_WAIT
done  out  1  high in HALT
err  out  1  high in HALT when entered by timeout
cycle_cnt  out  CNT_W  cycles spent running

Behaviour:
- Opcode classes:
  - jg = 10000xxxx; jge = 10001xxxx; jmp = 1001xxxxx.
  - ldr = 101110xxx; str = 101111xxx; ldi = 110000xxx; sti = 110001xxx.
  - halt = 111111111.
  - Everything else is single-cycle ALU/move.
- States: IDLE, EXEC, MEM_WAIT, HALT.
- Reset (reset_n=0 at a clock edge, any state, including mid MEM_WAIT):
  - state=IDLE; pc=0; cycle_cnt=0; wait counter=0.
  - exec_en=0, mem_req=0, mem_we=0, running=0, done=0, err=0.
- IDLE:
  - All strobes 0.
  - start=1 -> pc<=0, cycle_cnt<=0, err<=0, go EXEC.
- EXEC (one instruction per cycle):
  - cycle_cnt increments every EXEC/MEM_WAIT cycle and saturates at all-ones.
  - ALU/move: exec_en=1 that cycle; pc<=pc+1.
  - jmp: exec_en=1; pc<=lut_target.
  - jg: exec_en=1; taken if gt_flag=1.
  - jge: exec_en=1; taken if gt_flag|eq_flag.
  - Branch targets: taken -> pc<=lut_target; not taken -> pc<=pc+1.
  - Memory op:
    - exec_en=0; mem_req=1 combinationally in the same cycle.
    - mem_we=1 for str/sti, 0 for ldr/ldi.
    - go MEM_WAIT with wait counter=1; pc holds.
  - halt: exec_en=0; pc holds; go HALT.
- MEM_WAIT:
  - mem_req=1 and mem_we held; instr is stable because pc is frozen.
  - mem_ack=1 -> exec_en=1 this cycle; pc<=pc+1; go EXEC.
  - No ack and wait counter==MAX_WAIT -> go HALT with err<=1.
  - Otherwise the wait counter increments.
  - mem_ack is ignored in every other state.
- HALT:
  - done=1; pc and cycle_cnt frozen.
  - start=1 -> same restart as from IDLE (pc<=0, cycle_cnt<=0, err<=0, EXEC); done drops the next cycle.
- start is ignored while running.
- pc+1 from 2^PC_W-1 wraps to 0.
- Memory latency: the request cycle plus N wait cycles gives N+1 cycles total; an ack in the first MEM_WAIT cycle gives 2 cycles total.
- Simultaneous events:
  - mem_ack in the cycle where wait counter==MAX_WAIT -> ack wins (retire, no err).
  - reset_n=0 overrides everything.
- lut_idx is driven in all states; consumers use it only for a jump in EXEC.

Test Plan:
- Reset/idle: reset_n=0 for 2 cycles, then start=0 for 5 cycles -> pc=0, running=0, done=0, all strobes 0.
- Straight-line: ROM {ALU, ALU, ALU, halt}, pulse start -> exec_en high 3 consecutive cycles; pc 0,1,2,3; done=1 with pc=3, cycle_cnt=4.
- Branches:
  - instr 100000101 with gt_flag=0, eq_flag=1, lut_target=0x20 -> pc becomes 1.
  - Same with 100010101 -> pc becomes 0x20.
  - jmp 100101111 -> lut_idx=0xF; pc<=lut_target.
- Memory stall: str at pc=4, mem_ack after 3 wait cycles -> mem_req=1, mem_we=1 for 4 cycles; exec_en only in the ack cycle; pc=5 next cycle.
- Timeout: ldr with mem_ack held 0, MAX_WAIT=15 -> mem_req high 16 cycles, then done=1, err=1. Repeat with ack on exactly the 16th cycle -> retires, err=0.
- Reset mid-stall and wrap:
  - reset_n=0 during MEM_WAIT -> next cycle IDLE, mem_req=0.
  - PC_W=8, ALU at pc=255 -> pc becomes 0.
  - start while running is ignored.
